// File: rtl/display_timings_gen.sv
// Pixel-clock raster timing: signed sx/sy counters with registered, zero-skew sync/enable/strobes.
// Optional frame_count output is enabled by defining DISPLAY_TIMINGS_FRAME_COUNT_EN.
`timescale 1ns/1ps
module display_timings_gen #(
  parameter int COORDSPC = 16,
  parameter int H_RES    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_RES    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0
) (
  input  logic                       video_clk_pix,
  input  logic                       rst_pix,
  output logic signed [COORDSPC-1:0] sx,
  output logic signed [COORDSPC-1:0] sy,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       video_enable,
  output logic                       frame_start,
  output logic                       line_start
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
  ,
  output logic [15:0]                frame_count
`endif
);

  localparam int H_STA_I = -(H_FP + H_SYNC + H_BP);
  localparam int H_END_I = H_RES - 1;
  localparam int V_STA_I = -(V_FP + V_SYNC + V_BP);
  localparam int V_END_I = V_RES - 1;
  localparam longint C_MIN = -(longint'(1) << (COORDSPC - 1));
  localparam longint C_MAX = (longint'(1) << (COORDSPC - 1)) - 1;

  if (H_STA_I < C_MIN || H_END_I > C_MAX || V_STA_I < C_MIN || V_END_I > C_MAX) begin : g_width_chk
    $error("display_timings_gen: COORDSPC too narrow for the configured timing range");
  end

  localparam logic signed [COORDSPC-1:0] H_STA  = COORDSPC'(H_STA_I);
  localparam logic signed [COORDSPC-1:0] H_END  = COORDSPC'(H_END_I);
  localparam logic signed [COORDSPC-1:0] V_STA  = COORDSPC'(V_STA_I);
  localparam logic signed [COORDSPC-1:0] V_END  = COORDSPC'(V_END_I);
  localparam logic signed [COORDSPC-1:0] HS_BEG = COORDSPC'(H_STA_I + H_FP);
  localparam logic signed [COORDSPC-1:0] HS_END = COORDSPC'(H_STA_I + H_FP + H_SYNC - 1);
  localparam logic signed [COORDSPC-1:0] VS_BEG = COORDSPC'(V_STA_I + V_FP);
  localparam logic signed [COORDSPC-1:0] VS_END = COORDSPC'(V_STA_I + V_FP + V_SYNC - 1);
  localparam logic signed [COORDSPC-1:0] ZERO   = COORDSPC'(0);
  localparam logic signed [COORDSPC-1:0] ONE    = COORDSPC'(1);

  // Cleared by reset so the first cycle after release presents (H_STA, V_STA) before counting.
  logic                       running;
  logic signed [COORDSPC-1:0] sx_nxt;
  logic signed [COORDSPC-1:0] sy_nxt;

  always_comb begin
    sx_nxt = sx;
    sy_nxt = sy;
    if (running) begin
      if (sx == H_END) begin
        sx_nxt = H_STA;
        sy_nxt = (sy == V_END) ? V_STA : sy + ONE;
      end else begin
        sx_nxt = sx + ONE;
      end
    end
  end

  // Decodes use the next coordinates so every flag lands in the same cycle as its sx/sy.
  always_ff @(posedge video_clk_pix) begin
    if (rst_pix) begin
      running      <= 1'b0;
      sx           <= H_STA;
      sy           <= V_STA;
      hsync        <= ~H_POL;
      vsync        <= ~V_POL;
      video_enable <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      running      <= 1'b1;
      sx           <= sx_nxt;
      sy           <= sy_nxt;
      hsync        <= (sx_nxt >= HS_BEG && sx_nxt <= HS_END) ? H_POL : ~H_POL;
      vsync        <= (sy_nxt >= VS_BEG && sy_nxt <= VS_END) ? V_POL : ~V_POL;
      video_enable <= (sx_nxt >= ZERO) && (sy_nxt >= ZERO);
      line_start   <= (sx_nxt == H_STA);
      frame_start  <= (sx_nxt == H_STA) && (sy_nxt == V_STA);
    end
  end

`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
  always_ff @(posedge video_clk_pix) begin
    if (rst_pix) begin
      frame_count <= 16'd0;
    end else if (frame_start) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule
